// File: rtl/accelerator_tcdm_arbiter.sv
// accelerator_tcdm_arbiter
// Shares one wide TCDM initiator port between the X load (0), Y load (1) and
// Z store (2) stream requesters. Round-robin arbitration; a stalled request
// keeps its slot until granted. An in-order ID FIFO steers each response back
// to the requester that issued it.
// Optional build macro: ACC_ARB_Z_PRIORITY_EN gives the Z store requester
// priority over the round-robin choice (an existing lock is still honoured).
module accelerator_tcdm_arbiter #(
    parameter int unsigned DW              = 256,
    parameter int unsigned AW              = 32,
    parameter int unsigned NR              = 3,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic [NR-1:0]        req_i,
    output logic [NR-1:0]        gnt_o,
    input  logic [NR*AW-1:0]     add_i,
    input  logic [NR-1:0]        wen_i,
    input  logic [NR*DW/8-1:0]   be_i,
    input  logic [NR*DW-1:0]     data_i,
    output logic [DW-1:0]        r_data_o,
    output logic [NR-1:0]        r_valid_o,
    output logic                 tcdm_req_o,
    input  logic                 tcdm_gnt_i,
    output logic [AW-1:0]        tcdm_add_o,
    output logic                 tcdm_wen_o,
    output logic [DW/8-1:0]      tcdm_be_o,
    output logic [DW-1:0]        tcdm_data_o,
    input  logic [DW-1:0]        tcdm_r_data_i,
    input  logic                 tcdm_r_valid_i,
    output logic                 busy_o,
    output logic                 error_o
);

    localparam int unsigned IW = (NR > 1) ? $clog2(NR) : 1;
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NR - 1);

    logic [IW-1:0] rr_ptr;
    logic          lock;
    logic [IW-1:0] lock_idx;

    logic [IW-1:0] id_mem [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          fifo_full_eff;
    logic [NR-1:0] eligible;
    logic [IW-1:0] rr_sel;
    logic [IW-1:0] sel;
    logic          accept;
    logic          stall;
    logic [IW-1:0] head;

    assign fifo_full     = (count == CW'(MAX_OUTSTANDING));
    assign fifo_empty    = (count == '0);
    assign pop           = tcdm_r_valid_i & ~fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign fifo_full_eff = fifo_full & ~pop;
    assign eligible      = req_i & {NR{~fifo_full_eff}};

    // Round-robin search: first eligible index at or after rr_ptr, modulo NR.
    always_comb begin
        int          cand;
        logic [IW-1:0] cand_idx;
        logic        found;
        cand     = 0;
        cand_idx = '0;
        found    = 1'b0;
        rr_sel   = rr_ptr;
        for (int i = 0; i < int'(NR); i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= int'(NR)) cand = cand - int'(NR);
            cand_idx = IW'(cand);
            if (!found && eligible[cand_idx]) begin
                found  = 1'b1;
                rr_sel = cand_idx;
            end
        end
    end

    // Final selection: a held lock wins, then (optionally) Z, then round-robin.
    always_comb begin
        sel = rr_sel;
        if (lock) begin
            sel = lock_idx;
        end
`ifdef ACC_ARB_Z_PRIORITY_EN
        else if (eligible[2]) begin
            sel = IW'(2);
        end
`endif
    end

    assign tcdm_req_o = eligible[sel];
    assign accept     = tcdm_req_o & tcdm_gnt_i;
    assign stall      = tcdm_req_o & ~tcdm_gnt_i;
    assign push       = accept;

    // Downstream request mux; fields are zero when nothing is requested.
    always_comb begin
        tcdm_add_o  = '0;
        tcdm_wen_o  = 1'b0;
        tcdm_be_o   = '0;
        tcdm_data_o = '0;
        if (tcdm_req_o) begin
            tcdm_add_o  = add_i[int'(sel)*AW +: AW];
            tcdm_wen_o  = wen_i[sel];
            tcdm_be_o   = be_i[int'(sel)*(DW/8) +: DW/8];
            tcdm_data_o = data_i[int'(sel)*DW +: DW];
        end
    end

    assign head = id_mem[rd_ptr];

    // Grant and response steering, both combinational.
    always_comb begin
        gnt_o     = '0;
        r_valid_o = '0;
        for (int k = 0; k < int'(NR); k++) begin
            gnt_o[k]     = accept & (sel == IW'(k));
            r_valid_o[k] = pop & (head == IW'(k));
        end
    end

    assign r_data_o = tcdm_r_data_i;
    assign busy_o   = (|req_i) | ~fifo_empty;

    // Arbitration state: round-robin pointer and stall lock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
        end else if (clear_i) begin
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
        end else begin
            if (accept) begin
                lock <= 1'b0;
`ifdef ACC_ARB_Z_PRIORITY_EN
                if (sel != IW'(2)) begin
                    rr_ptr <= (sel == LAST_IDX) ? '0 : sel + IW'(1);
                end
`else
                rr_ptr <= (sel == LAST_IDX) ? '0 : sel + IW'(1);
`endif
            end else if (stall) begin
                lock     <= 1'b1;
                lock_idx <= sel;
            end else if (lock && !req_i[lock_idx]) begin
                // Locked requester withdrew its request: just release the lock.
                lock <= 1'b0;
            end
        end
    end

    // ID FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ID FIFO storage; contents are don't-care while unoccupied.
    always_ff @(posedge clk_i) begin
        if (push && !clear_i) id_mem[wr_ptr] <= sel;
    end

    // Sticky error: a response arrived with nothing outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            error_o <= 1'b0;
        end else if (clear_i) begin
            error_o <= 1'b0;
        end else if (tcdm_r_valid_i && fifo_empty) begin
            error_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_accelerator_tcdm_arbiter.sv
// Directed bench for accelerator_tcdm_arbiter (default build: pure round-robin).
module tb_accelerator_tcdm_arbiter;

    localparam int DW = 256;
    localparam int AW = 32;
    localparam int NR = 3;

    localparam logic [AW-1:0] ADDR0 = 32'h0000_1000;
    localparam logic [AW-1:0] ADDR1 = 32'h0000_2010;
    localparam logic [AW-1:0] ADDR2 = 32'h0000_3020;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic [NR-1:0]     req;
    logic [NR-1:0]     gnt;
    logic [NR*AW-1:0]  add;
    logic [NR-1:0]     wen;
    logic [NR*DW/8-1:0] be;
    logic [NR*DW-1:0]  data;
    logic [DW-1:0]     r_data;
    logic [NR-1:0]     r_valid;
    logic              tcdm_req;
    logic              tcdm_gnt;
    logic [AW-1:0]     tcdm_add;
    logic              tcdm_wen;
    logic [DW/8-1:0]   tcdm_be;
    logic [DW-1:0]     tcdm_data;
    logic [DW-1:0]     tcdm_r_data;
    logic              tcdm_r_valid;
    logic              busy;
    logic              error;

    int checks;
    int failures;

    logic [DW-1:0] pat_x;
    logic [DW-1:0] pat_y;
    logic [DW-1:0] pat_z;

    accelerator_tcdm_arbiter #(
        .DW(DW), .AW(AW), .NR(NR), .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .req_i          (req),
        .gnt_o          (gnt),
        .add_i          (add),
        .wen_i          (wen),
        .be_i           (be),
        .data_i         (data),
        .r_data_o       (r_data),
        .r_valid_o      (r_valid),
        .tcdm_req_o     (tcdm_req),
        .tcdm_gnt_i     (tcdm_gnt),
        .tcdm_add_o     (tcdm_add),
        .tcdm_wen_o     (tcdm_wen),
        .tcdm_be_o      (tcdm_be),
        .tcdm_data_o    (tcdm_data),
        .tcdm_r_data_i  (tcdm_r_data),
        .tcdm_r_valid_i (tcdm_r_valid),
        .busy_o         (busy),
        .error_o        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle's inputs, then let combinational outputs settle.
    task automatic drive(input logic [NR-1:0] r, input logic g, input logic rv);
        req          = r;
        tcdm_gnt     = g;
        tcdm_r_valid = rv;
        #1;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        pat_x        = {32{8'h11}};
        pat_y        = {32{8'h22}};
        pat_z        = {32{8'hA5}};
        rst_n        = 1'b0;
        clear        = 1'b0;
        req          = '0;
        tcdm_gnt     = 1'b0;
        tcdm_r_valid = 1'b0;
        tcdm_r_data  = {8{32'hCAFE_0001}};
        add          = {ADDR2, ADDR1, ADDR0};
        wen          = 3'b011;
        be           = {32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_FF00};
        data         = {pat_z, pat_y, pat_x};

        // ---------------- reset state ----------------
        #2;
        chk("rst_gnt", DW'(gnt), DW'(3'b000));
        chk("rst_rvalid", DW'(r_valid), DW'(3'b000));
        chk("rst_tcdm_req", DW'(tcdm_req), DW'(1'b0));
        chk("rst_tcdm_add", DW'(tcdm_add), DW'(0));
        chk("rst_busy", DW'(busy), DW'(1'b0));
        chk("rst_error", DW'(error), DW'(1'b0));
        chk("rst_rdata", r_data, {8{32'hCAFE_0001}});
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- round robin, all requesting ----------------
        drive(3'b111, 1'b1, 1'b0);
        chk("rr0_gnt", DW'(gnt), DW'(3'b001));
        chk("rr0_add", DW'(tcdm_add), DW'(ADDR0));
        chk("rr0_rvalid", DW'(r_valid), DW'(3'b000));
        tick();
        drive(3'b111, 1'b1, 1'b1);
        chk("rr1_gnt", DW'(gnt), DW'(3'b010));
        chk("rr1_add", DW'(tcdm_add), DW'(ADDR1));
        chk("rr1_rvalid", DW'(r_valid), DW'(3'b001));
        tick();
        drive(3'b111, 1'b1, 1'b1);
        chk("rr2_gnt", DW'(gnt), DW'(3'b100));
        chk("rr2_add", DW'(tcdm_add), DW'(ADDR2));
        chk("rr2_wen", DW'(tcdm_wen), DW'(1'b0));
        chk("rr2_rvalid", DW'(r_valid), DW'(3'b010));
        tick();
        drive(3'b111, 1'b1, 1'b1);
        chk("rr3_gnt", DW'(gnt), DW'(3'b001));
        chk("rr3_rvalid", DW'(r_valid), DW'(3'b100));
        tick();
        drive(3'b111, 1'b1, 1'b1);
        chk("rr4_gnt", DW'(gnt), DW'(3'b010));
        chk("rr4_rvalid", DW'(r_valid), DW'(3'b001));
        tick();
        drive(3'b111, 1'b1, 1'b1);
        chk("rr5_gnt", DW'(gnt), DW'(3'b100));
        chk("rr5_rvalid", DW'(r_valid), DW'(3'b010));
        tick();
        drive(3'b111, 1'b1, 1'b1);
        chk("rr6_gnt", DW'(gnt), DW'(3'b001));
        chk("rr6_rvalid", DW'(r_valid), DW'(3'b100));
        tick();
        drive(3'b111, 1'b1, 1'b1);
        chk("rr7_gnt", DW'(gnt), DW'(3'b010));
        chk("rr7_rvalid", DW'(r_valid), DW'(3'b001));
        tick();
        drive(3'b111, 1'b1, 1'b1);
        chk("rr8_gnt", DW'(gnt), DW'(3'b100));
        chk("rr8_rvalid", DW'(r_valid), DW'(3'b010));
        tick();
        drive(3'b000, 1'b0, 1'b1);
        chk("rr9_tcdm_req", DW'(tcdm_req), DW'(1'b0));
        chk("rr9_rvalid", DW'(r_valid), DW'(3'b100));
        tick();
        drive(3'b000, 1'b0, 1'b0);
        chk("rr_error", DW'(error), DW'(1'b0));
        chk("rr_busy", DW'(busy), DW'(1'b0));

        // ---------------- stall / lock ----------------
        for (int i = 0; i < 3; i++) begin
            drive(3'b011, 1'b0, 1'b0);
            chk("stall_req", DW'(tcdm_req), DW'(1'b1));
            chk("stall_add", DW'(tcdm_add), DW'(ADDR0));
            chk("stall_gnt", DW'(gnt), DW'(3'b000));
            tick();
        end
        drive(3'b011, 1'b1, 1'b0);
        chk("stall_rel_gnt", DW'(gnt), DW'(3'b001));
        tick();
        drive(3'b010, 1'b1, 1'b0);
        chk("after_stall_gnt", DW'(gnt), DW'(3'b010));
        chk("after_stall_add", DW'(tcdm_add), DW'(ADDR1));
        tick();
        // rr_ptr now 2; X alone stalls and locks, then Z joins.
        drive(3'b001, 1'b0, 1'b0);
        chk("lock_x_req", DW'(tcdm_req), DW'(1'b1));
        tick();
        drive(3'b101, 1'b0, 1'b0);
        chk("lock_hold_add", DW'(tcdm_add), DW'(ADDR0));
        chk("lock_hold_gnt", DW'(gnt), DW'(3'b000));
        tick();
        drive(3'b101, 1'b1, 1'b0);
        chk("lock_rel_gnt", DW'(gnt), DW'(3'b001));
        tick();
        drive(3'b100, 1'b1, 1'b0);
        chk("lock_next_gnt", DW'(gnt), DW'(3'b100));
        tick();
        drive(3'b000, 1'b0, 1'b1);
        chk("drain0_rvalid", DW'(r_valid), DW'(3'b001));
        chk("drain0_busy", DW'(busy), DW'(1'b1));
        tick();
        drive(3'b000, 1'b0, 1'b1);
        chk("drain1_rvalid", DW'(r_valid), DW'(3'b010));
        tick();
        drive(3'b000, 1'b0, 1'b1);
        chk("drain2_rvalid", DW'(r_valid), DW'(3'b001));
        tick();
        drive(3'b000, 1'b0, 1'b1);
        chk("drain3_rvalid", DW'(r_valid), DW'(3'b100));
        tick();
        drive(3'b000, 1'b0, 1'b0);
        chk("drain_busy", DW'(busy), DW'(1'b0));
        chk("drain_error", DW'(error), DW'(1'b0));

        // ---------------- FIFO full ----------------
        for (int i = 0; i < 4; i++) begin
            drive(3'b001, 1'b1, 1'b0);
            chk("fill_gnt", DW'(gnt), DW'(3'b001));
            chk("fill_wen", DW'(tcdm_wen), DW'(1'b1));
            tick();
        end
        drive(3'b001, 1'b1, 1'b0);
        chk("full_tcdm_req", DW'(tcdm_req), DW'(1'b0));
        chk("full_gnt", DW'(gnt), DW'(3'b000));
        chk("full_busy", DW'(busy), DW'(1'b1));
        tick();
        drive(3'b001, 1'b1, 1'b1);
        chk("full_poppush_req", DW'(tcdm_req), DW'(1'b1));
        chk("full_poppush_gnt", DW'(gnt), DW'(3'b001));
        chk("full_poppush_rvalid", DW'(r_valid), DW'(3'b001));
        tick();
        drive(3'b001, 1'b1, 1'b0);
        chk("still_full_req", DW'(tcdm_req), DW'(1'b0));
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(3'b000, 1'b0, 1'b1);
            chk("full_drain_rvalid", DW'(r_valid), DW'(3'b001));
            tick();
        end
        drive(3'b000, 1'b0, 1'b0);
        chk("full_drain_busy", DW'(busy), DW'(1'b0));

        // ---------------- Z write pass-through ----------------
        drive(3'b100, 1'b1, 1'b0);
        chk("z_gnt", DW'(gnt), DW'(3'b100));
        chk("z_wen", DW'(tcdm_wen), DW'(1'b0));
        chk("z_be", DW'(tcdm_be), DW'(32'hFFFF_FFFF));
        chk("z_data", tcdm_data, {32{8'hA5}});
        chk("z_add", DW'(tcdm_add), DW'(ADDR2));
        tick();
        drive(3'b000, 1'b0, 1'b1);
        chk("z_rvalid", DW'(r_valid), DW'(3'b100));
        tick();

        // ---------------- spurious response ----------------
        drive(3'b000, 1'b0, 1'b1);
        chk("spur_rvalid", DW'(r_valid), DW'(3'b000));
        chk("spur_error_now", DW'(error), DW'(1'b0));
        tick();
        drive(3'b000, 1'b0, 1'b0);
        chk("spur_error_next", DW'(error), DW'(1'b1));
        tick();
        chk("spur_error_sticky", DW'(error), DW'(1'b1));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        chk("clear_error", DW'(error), DW'(1'b0));

        // ---------------- reset with outstanding + lock ----------------
        drive(3'b011, 1'b1, 1'b0);
        chk("pre_rst_gnt0", DW'(gnt), DW'(3'b001));
        tick();
        drive(3'b010, 1'b1, 1'b0);
        chk("pre_rst_gnt1", DW'(gnt), DW'(3'b010));
        tick();
        drive(3'b001, 1'b0, 1'b0);
        chk("pre_rst_lock_req", DW'(tcdm_req), DW'(1'b1));
        tick();
        tcdm_r_data = {8{32'h5A5A_0F0F}};
        drive(3'b000, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", DW'(busy), DW'(1'b0));
        chk("mid_rst_error", DW'(error), DW'(1'b0));
        chk("mid_rst_rvalid", DW'(r_valid), DW'(3'b000));
        chk("mid_rst_tcdm_req", DW'(tcdm_req), DW'(1'b0));
        chk("mid_rst_gnt", DW'(gnt), DW'(3'b000));
        chk("mid_rst_rdata", r_data, {8{32'h5A5A_0F0F}});
        tick();
        rst_n = 1'b1;
        tick();
        drive(3'b111, 1'b1, 1'b0);
        chk("post_rst_gnt", DW'(gnt), DW'(3'b001));
        tick();
        drive(3'b000, 1'b0, 1'b1);
        chk("post_rst_rvalid", DW'(r_valid), DW'(3'b001));
        tick();
        drive(3'b000, 1'b0, 1'b0);
        chk("post_rst_busy", DW'(busy), DW'(1'b0));
        chk("post_rst_error", DW'(error), DW'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/accelerator_tcdm_arbiter.md
Name: accelerator_tcdm_arbiter

Overview:
- Shares the single wide TCDM initiator port of accelerator_streamer between the three stream requesters: X load (idx 0), Y load (idx 1) and Z store (idx 2).
- Round-robin arbitration with a held selection while a request stalls.
- An in-order ID FIFO routes each TCDM response back to the requester that issued it.
- Sits between the per-stream HCI sources and the tcdm port of the streamer.

Parameters:
- DW, 256, TCDM data width in bits (MP*32).
- AW, 32, address width.
- NR, 3, number of requesters (fixed order X, Y, Z).
- MAX_OUTSTANDING, 4, ID FIFO depth = max in-flight transactions, power of 2, ≥2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous soft clear
- req_i  in  NR  requester request
- gnt_o  out  NR  requester grant
- add_i  in  NR*AW  requester addresses, requester k at [k*AW +: AW]
- wen_i  in  NR  1=read, 0=write
- be_i  in  NR*DW/8  byte enables
- data_i  in  NR*DW  write data
- r_data_o  out  DW  response data, broadcast to all requesters
- r_valid_o  out  NR  per-requester response valid
- tcdm_req_o  out  1  downstream request
- tcdm_gnt_i  in  1  downstream grant
- tcdm_add_o  out  AW  downstream address
- tcdm_wen_o  out  1  downstream wen
- tcdm_be_o  out  DW/8  downstream byte enables
- tcdm_data_o  out  DW  downstream write data
- tcdm_r_data_i  in  DW  downstream response data
- tcdm_r_valid_i  in  1  downstream response valid
- busy_o  out  1  any request pending or FIFO non-empty
- error_o  out  1  sticky: response received with empty FIFO

Behaviour:
- Reset/clear: rr_ptr=0, lock=0, FIFO empty, error_o=0. All outputs 0 except r_data_o, which follows tcdm_r_data_i.
- Eligible requesters: eligible[k] = req_i[k] & !fifo_full_eff. fifo_full_eff = full & !pop this cycle, so push and pop in the same cycle are allowed when full.
- Selection when unlocked: first eligible index at or after rr_ptr, searching modulo NR.
- Selection when locked: lock_idx is held, ignoring priority.
- Downstream mux is combinational: tcdm_req_o = eligible[sel]. tcdm_add/wen/be/data come from sel, else 0.
- Grant is combinational: gnt_o[k] = tcdm_gnt_i & tcdm_req_o & (sel==k).
- Accept = tcdm_req_o & tcdm_gnt_i. On accept:
  - push sel into the FIFO;
  - rr_ptr <= (sel+1) mod NR;
  - lock <= 0.
- Stall = tcdm_req_o & !tcdm_gnt_i. On stall: lock <= 1, lock_idx <= sel. The requester is never switched until granted.
- If the locked requester drops req_i (protocol violation), lock clears next cycle with no other effect.
- Every accepted transaction, read or write, expects exactly one tcdm_r_valid_i pulse, in order, at least 1 cycle after the accept.
- On tcdm_r_valid_i: pop the FIFO head h; r_valid_o = onehot(h) in the same cycle (combinational). A zero-latency response in the accept cycle is not supported.
- On tcdm_r_valid_i with empty FIFO: no r_valid_o, error_o <= 1 (sticky until reset/clear).
- The FIFO uses wrap-around pointers plus a count of log2(MAX_OUTSTANDING)+1 bits.
- busy_o = |req_i | (count != 0).
- clear_i takes priority over the same-cycle accept and pop.

Optional Feature:
- ACC_ARB_Z_PRIORITY_EN defined: the Z requester (idx 2), when eligible and not locked out, wins over the round-robin choice. An existing lock is still honoured. rr_ptr updates only on X/Y accepts.
- Undefined: pure round-robin for all three requesters.

Test Plan:
- All three req_i high continuously, tcdm_gnt_i=1, response 1 cycle later, 9 accepts → grant order 0,1,2,0,1,2,0,1,2. r_valid_o follows the same order, one cycle behind. error_o=0.
- X requests, tcdm_gnt_i=0 for 3 cycles while Y also requests → sel stays 0 and add_o is stable. Grant on cycle 4 to X; the next grant goes to Y.
- Responses withheld, X issues reads → after 4 accepts tcdm_req_o=0 (FIFO full). Raise r_valid with a new req in the same cycle → accept proceeds and count stays 4.
- Z write data=0xA5.., be all ones → tcdm_wen_o=0 and data passes through. The response pulse yields r_valid_o=3'b100.
- tcdm_r_valid_i pulse with no outstanding transaction → r_valid_o=0 and error_o=1 from the next cycle. clear_i → error_o=0.
- rst_ni asserted with 2 outstanding and a lock held → all outputs 0, FIFO empty. Post-reset the first grant goes to idx 0.
- With ACC_ARB_Z_PRIORITY_EN: all requesting → order 2,2,2… while Z holds req_i. Z drops → 0,1 alternate.
